// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART: parity modes, serializer and
// deserializer state encodings, and the bit-period divisor.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

   // Clocks per bit, rounded to nearest.
   function automatic int uart_div(input int clock_hz, input int baud);
      return (clock_hz + baud / 2) / baud;
   endfunction

   // Line value of the parity bit for a word whose XOR-reduction is x.
   function automatic logic parity_bit(input parity_e mode, input logic x);
      return (mode == PAR_ODD) ? ~x : x;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO with a registered occupancy count.
// The head entry is presented combinationally and reads as zero while empty.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             ready_o,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] rd_data_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign ready_o   = (count_q != CW'(DEPTH));
   assign valid_o   = (count_q != '0);
   assign do_push   = push_i & ready_o;
   assign do_pop    = pop_i & valid_o;
   assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

   // NOTE: storage has no reset; an entry is always written before valid_o can expose it.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_buffered.sv
// Full-duplex UART with TX/RX FIFOs, valid/ready byte streams, configurable
// framing and sticky overrun/framing/parity error flags.
module uart_buffered
   import uart_pkg::*;
#(
   parameter int CLOCK_HZ  = 48000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic       tx,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       tx_busy,
   input  logic       err_clear,
   output logic       overrun,
   output logic       framing_err,
   output logic       parity_err
);

   localparam int               DIV       = uart_div(CLOCK_HZ, BAUD);
   localparam int               CNT_W     = $clog2(DIV);
   localparam parity_e          PAR       = parity_e'(PARITY);
   localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] DIV_HALF  = CNT_W'(DIV / 2);
   localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

   // ---------------- transmit path ----------------
   logic                 txf_valid;
   logic [DATA_BITS-1:0] txf_data;
   logic                 tx_pop;
   logic                 tx_tick;
   tx_state_e            tx_state_q;
   logic [CNT_W-1:0]     tx_cnt_q;
   logic [2:0]           tx_bit_q;
   logic [DATA_BITS-1:0] tx_shift_q;
   logic                 tx_par_q;
   logic                 tx_q;

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_tx_fifo (
      .clk       (clock),
      .rst_n     (reset_n),
      .push_i    (tx_valid),
      .wr_data_i (tx_data[DATA_BITS-1:0]),
      .ready_o   (tx_ready),
      .pop_i     (tx_pop),
      .valid_o   (txf_valid),
      .rd_data_o (txf_data)
   );

   assign tx_tick = (tx_cnt_q == '0);
   // Popping at the end of the last stop bit starts the next frame with no idle gap.
   assign tx_pop  = txf_valid &&
                    ((tx_state_q == TX_IDLE) ||
                     (tx_state_q == TX_STOP && tx_tick && tx_bit_q == LAST_STOP));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else if (tx_pop) begin
         tx_state_q <= TX_START;
         tx_cnt_q   <= DIV_M1;
         tx_bit_q   <= '0;
         tx_shift_q <= txf_data;
         tx_par_q   <= parity_bit(PAR, ^txf_data);
         tx_q       <= 1'b0;
      end else if (tx_state_q != TX_IDLE) begin
         if (!tx_tick) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
         end else begin
            tx_cnt_q <= DIV_M1;
            case (tx_state_q)
               TX_START: begin
                  tx_state_q <= TX_DATA;
                  tx_q       <= tx_shift_q[0];
               end
               TX_DATA: begin
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_q       <= tx_shift_q[1];
                  tx_bit_q   <= tx_bit_q + 1'b1;
                  if (tx_bit_q == LAST_DATA) begin
                     tx_bit_q <= '0;
                     if (PAR == PAR_NONE) begin
                        tx_state_q <= TX_STOP;
                        tx_q       <= 1'b1;
                     end else begin
                        tx_state_q <= TX_PARITY;
                        tx_q       <= tx_par_q;
                     end
                  end
               end
               TX_PARITY: begin
                  tx_state_q <= TX_STOP;
                  tx_q       <= 1'b1;
               end
               TX_STOP: begin
                  tx_bit_q <= tx_bit_q + 1'b1;
                  if (tx_bit_q == LAST_STOP) begin
                     tx_state_q <= TX_IDLE;
                     tx_bit_q   <= '0;
                  end
               end
               default: tx_state_q <= TX_IDLE;
            endcase
         end
      end
   end

   assign tx      = tx_q;
   assign tx_busy = (tx_state_q != TX_IDLE) || txf_valid;

   // ---------------- receive path ----------------
   logic [1:0]           rx_sync_q;
   logic                 rx_s;
   rx_state_e            rx_state_q;
   logic [CNT_W-1:0]     rx_cnt_q;
   logic [2:0]           rx_bit_q;
   logic [DATA_BITS-1:0] rx_shift_q;
   logic                 rx_par_q;
   logic                 rx_tick;
   logic                 stop_sample;
   logic                 parity_ok;
   logic                 rxf_ready;
   logic                 rxf_valid;
   logic [DATA_BITS-1:0] rxf_data;
   logic                 rx_push;
   logic                 set_frm;
   logic                 set_par;
   logic                 set_ovr;
   logic                 overrun_q;
   logic                 framing_q;
   logic                 parity_q;

   // Synchronizer resets to the idle-high line level so reset release cannot fake a start bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rx_sync_q <= 2'b11;
      else          rx_sync_q <= {rx_sync_q[0], rx};
   end
   assign rx_s = rx_sync_q[1];

   assign rx_tick     = (rx_cnt_q == '0);
   assign stop_sample = (rx_state_q == RX_STOP) && rx_tick;
   assign parity_ok   = (PAR == PAR_NONE) || (rx_par_q == parity_bit(PAR, ^rx_shift_q));
   assign set_frm     = stop_sample && !rx_s;
   assign set_par     = stop_sample && rx_s && !parity_ok;
   assign set_ovr     = stop_sample && rx_s && parity_ok && !rxf_ready;
   assign rx_push     = stop_sample && rx_s && parity_ok && rxf_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_state_q <= RX_START;
                  rx_cnt_q   <= DIV_HALF;
               end
            end
            RX_WAIT_HIGH: begin
               if (rx_s) rx_state_q <= RX_IDLE;
            end
            default: begin
               if (!rx_tick) begin
                  rx_cnt_q <= rx_cnt_q - 1'b1;
               end else begin
                  rx_cnt_q <= DIV_M1;
                  case (rx_state_q)
                     RX_START: begin
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
                     end
                     RX_DATA: begin
                        rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == LAST_DATA) begin
                           rx_bit_q   <= '0;
                           rx_state_q <= (PAR == PAR_NONE) ? RX_STOP : RX_PARITY;
                        end
                     end
                     RX_PARITY: begin
                        rx_par_q   <= rx_s;
                        rx_state_q <= RX_STOP;
                     end
                     RX_STOP: rx_state_q <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                     default: rx_state_q <= RX_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clock),
      .rst_n     (reset_n),
      .push_i    (rx_push),
      .wr_data_i (rx_shift_q),
      .ready_o   (rxf_ready),
      .pop_i     (rx_ready),
      .valid_o   (rxf_valid),
      .rd_data_o (rxf_data)
   );

   assign rx_valid = rxf_valid;
   assign rx_data  = 8'(rxf_data);

   // A set event in the same cycle as err_clear wins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overrun_q <= 1'b0;
         framing_q <= 1'b0;
         parity_q  <= 1'b0;
      end else begin
         overrun_q <= set_ovr | (overrun_q & ~err_clear);
         framing_q <= set_frm | (framing_q & ~err_clear);
         parity_q  <= set_par | (parity_q & ~err_clear);
      end
   end

   assign overrun     = overrun_q;
   assign framing_err = framing_q;
   assign parity_err  = parity_q;

endmodule

// File: tb/tb_uart_buffered.sv
// Self-checking bench for uart_buffered: an 8N1 instance with optional loopback
// and a 7E1 instance driven directly, both at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_buffered;

   localparam int DIV    = 10;
   localparam int FRAME  = 10 * DIV;
   localparam int BUDGET = 20000;
   localparam int LOG_N  = 32768;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // ---- instance A: 8N1, rx optionally looped back from tx ----
   logic       loop_a, rx_drv_a, rx_a, tx_a;
   logic       tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, tx_busy_a;
   logic [7:0] tx_data_a, rx_data_a;
   logic       err_clear_a, overrun_a, framing_a, parity_a;

   assign rx_a = loop_a ? tx_a : rx_drv_a;

   uart_buffered #(
      .CLOCK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(16)
   ) u_dut_a (
      .clock(clk), .reset_n(reset_n), .rx(rx_a), .tx(tx_a),
      .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
      .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_data(rx_data_a),
      .tx_busy(tx_busy_a), .err_clear(err_clear_a),
      .overrun(overrun_a), .framing_err(framing_a), .parity_err(parity_a)
   );

   // ---- instance B: 7 data bits, even parity ----
   logic       rx_drv_b, tx_b;
   logic       tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, tx_busy_b;
   logic [7:0] tx_data_b, rx_data_b;
   logic       err_clear_b, overrun_b, framing_b, parity_b;

   uart_buffered #(
      .CLOCK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DEPTH(16)
   ) u_dut_b (
      .clock(clk), .reset_n(reset_n), .rx(rx_drv_b), .tx(tx_b),
      .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
      .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_data(rx_data_b),
      .tx_busy(tx_busy_b), .err_clear(err_clear_b),
      .overrun(overrun_b), .framing_err(framing_b), .parity_err(parity_b)
   );

   // Per-cycle record of instance A's line and busy flag, sampled mid-cycle.
   logic tx_log   [LOG_N];
   logic busy_log [LOG_N];
   always @(negedge clk) begin
      tx_log[cyc % LOG_N]   = tx_a;
      busy_log[cyc % LOG_N] = tx_busy_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [7:0] d, output int t_acc);
      int n;
      n = 0;
      @(negedge clk);
      tx_valid_a = 1'b1;
      tx_data_a  = d;
      while (!tx_ready_a && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("push_accept", 32'(n < BUDGET), 32'd1);
      @(posedge clk);
      #1;
      tx_valid_a = 1'b0;
      t_acc = cyc;
   endtask

   task automatic pop_a();
      @(negedge clk);
      rx_ready_a = 1'b1;
      @(posedge clk);
      #1;
      rx_ready_a = 1'b0;
   endtask

   task automatic wait_idle_a(input int extra);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_busy_a && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(n < BUDGET), 32'd1);
      repeat (extra) @(negedge clk);
   endtask

   // Reference waveform: back-to-back 8N1 frames, frame j starting one cycle after acceptance + j*FRAME.
   task automatic check_wave(input logic [7:0] q [$], input int t0);
      int   span, j, r, p;
      logic e_tx, e_busy;
      span = q.size() * FRAME + 5;
      for (int k = 0; k < span; k++) begin
         e_busy = (k < 1 + q.size() * FRAME);
         if (k < 1) e_tx = 1'b1;
         else begin
            j = (k - 1) / FRAME;
            r = (k - 1) % FRAME;
            p = r / DIV;
            if (j >= q.size()) e_tx = 1'b1;
            else if (p == 0)   e_tx = 1'b0;
            else if (p <= 8)   e_tx = q[j][p-1];
            else               e_tx = 1'b1;
         end
         check($sformatf("tx_line@%0d", k), 32'(tx_log[(t0 + k) % LOG_N]), 32'(e_tx));
         check($sformatf("tx_busy@%0d", k), 32'(busy_log[(t0 + k) % LOG_N]), 32'(e_busy));
      end
   endtask

   task automatic drain_check_a(input logic [7:0] q [$]);
      foreach (q[i]) begin
         @(negedge clk);
         check($sformatf("rx_valid[%0d]", i), 32'(rx_valid_a), 32'd1);
         check($sformatf("rx_data[%0d]", i), 32'(rx_data_a), 32'(q[i]));
         pop_a();
      end
      @(negedge clk);
      check("rx_empty", 32'(rx_valid_a), 32'd0);
   endtask

   task automatic drive_bit(input int which, input logic v, input int cycles);
      @(negedge clk);
      if (which == 0) rx_drv_a = v;
      else            rx_drv_b = v;
      repeat (cycles - 1) @(negedge clk);
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input int nbits,
                             input logic use_par, input logic par, input logic stop);
      drive_bit(which, 1'b0, DIV);
      for (int i = 0; i < nbits; i++) drive_bit(which, d[i], DIV);
      if (use_par) drive_bit(which, par, DIV);
      drive_bit(which, stop, DIV);
   endtask

   initial begin
      logic [7:0] q [$];
      logic [7:0] b;
      int         t0, tdummy;

      reset_n     = 1'b0;
      loop_a      = 1'b1;
      rx_drv_a    = 1'b1;
      tx_valid_a  = 1'b0;
      tx_data_a   = '0;
      rx_ready_a  = 1'b0;
      err_clear_a = 1'b0;
      rx_drv_b    = 1'b1;
      tx_valid_b  = 1'b0;
      tx_data_b   = '0;
      rx_ready_b  = 1'b0;
      err_clear_b = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_tx_ready", 32'(tx_ready_a), 32'd1);
      check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
      check("rst_rx_data", 32'(rx_data_a), 32'd0);
      check("rst_tx_busy", 32'(tx_busy_a), 32'd0);
      check("rst_flags", {29'd0, overrun_a, framing_a, parity_a}, 32'd0);
      check("rst_b_tx", 32'(tx_b), 32'd1);
      check("rst_b_rx_valid", 32'(rx_valid_b), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // TX 8N1 waveform of 0xA5, looped back into the receiver.
      q = '{8'hA5};
      push_a(8'hA5, t0);
      wait_idle_a(30);
      check_wave(q, t0);
      drain_check_a(q);

      // Random burst sent back to back.
      q = {};
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 255)));
      push_a(q[0], t0);
      for (int i = 1; i < 6; i++) push_a(q[i], tdummy);
      wait_idle_a(30);
      check_wave(q, t0);
      drain_check_a(q);
      check("burst_flags", {29'd0, overrun_a, framing_a, parity_a}, 32'd0);

      // Loopback overrun: 18 bytes into a 16-entry receive FIFO.
      q = {};
      for (int i = 0; i < 18; i++) push_a(8'(i), tdummy);
      wait_idle_a(30);
      check("ovr_set", 32'(overrun_a), 32'd1);
      check("ovr_no_frm_par", {30'd0, framing_a, parity_a}, 32'd0);
      for (int i = 0; i < 16; i++) q.push_back(8'(i));
      drain_check_a(q);
      @(negedge clk);
      err_clear_a = 1'b1;
      @(posedge clk);
      #1;
      err_clear_a = 1'b0;
      @(negedge clk);
      check("ovr_cleared", 32'(overrun_a), 32'd0);

      // Parity on the 7E1 instance: wrong parity bit, then a correct frame.
      send_frame(1, 8'h41, 7, 1'b1, 1'b1, 1'b1);
      drive_bit(1, 1'b1, 2 * DIV);
      check("par_err_set", 32'(parity_b), 32'd1);
      check("par_no_push", 32'(rx_valid_b), 32'd0);
      send_frame(1, 8'h41, 7, 1'b1, 1'b0, 1'b1);
      drive_bit(1, 1'b1, 2 * DIV);
      check("par_good_valid", 32'(rx_valid_b), 32'd1);
      check("par_good_data", 32'(rx_data_b), 32'h41);
      check("par_err_sticky", 32'(parity_b), 32'd1);
      @(negedge clk);
      rx_ready_b = 1'b1;
      @(posedge clk);
      #1;
      rx_ready_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom_range(0, 127));
         send_frame(1, b, 7, 1'b1, ^b[6:0], 1'b1);
         drive_bit(1, 1'b1, 2 * DIV);
         check($sformatf("b_rand_valid[%0d]", i), 32'(rx_valid_b), 32'd1);
         check($sformatf("b_rand_data[%0d]", i), 32'(rx_data_b), 32'(b));
         @(negedge clk);
         rx_ready_b = 1'b1;
         @(posedge clk);
         #1;
         rx_ready_b = 1'b0;
      end
      check("b_other_flags", {30'd0, overrun_b, framing_b}, 32'd0);

      // Glitch: three clocks low must not start a frame.
      loop_a   = 1'b0;
      rx_drv_a = 1'b1;
      drive_bit(0, 1'b0, 3);
      drive_bit(0, 1'b1, 4 * DIV);
      check("glitch_no_push", 32'(rx_valid_a), 32'd0);
      check("glitch_no_flags", {29'd0, overrun_a, framing_a, parity_a}, 32'd0);

      // Framing error followed by a long break, then a clean frame.
      send_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1'b0);
      drive_bit(0, 1'b0, 30 * DIV);
      check("frm_set", 32'(framing_a), 32'd1);
      check("frm_no_push", 32'(rx_valid_a), 32'd0);
      check("frm_no_other", {30'd0, overrun_a, parity_a}, 32'd0);
      drive_bit(0, 1'b1, 2 * DIV);
      send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
      drive_bit(0, 1'b1, 2 * DIV);
      check("frm_recover_valid", 32'(rx_valid_a), 32'd1);
      check("frm_recover_data", 32'(rx_data_a), 32'h3C);
      check("frm_sticky", 32'(framing_a), 32'd1);

      // Reset during data bit 3 of the first of four queued bytes.
      loop_a = 1'b1;
      q = {};
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom_range(0, 255)));
      push_a(q[0], t0);
      for (int i = 1; i < 4; i++) push_a(q[i], tdummy);
      while (cyc < t0 + 45) @(negedge clk);
      check("pre_reset_bit3", 32'(tx_a), 32'(q[0][3]));
      reset_n = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx_a), 32'd1);
      check("mid_rst_busy", 32'(tx_busy_a), 32'd0);
      check("mid_rst_tx_ready", 32'(tx_ready_a), 32'd1);
      check("mid_rst_rx_valid", 32'(rx_valid_a), 32'd0);
      check("mid_rst_rx_data", 32'(rx_data_a), 32'd0);
      check("mid_rst_flags", {29'd0, overrun_a, framing_a, parity_a}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      check("post_rst_tx_idle", 32'(tx_a), 32'd1);
      check("post_rst_rx_empty", 32'(rx_valid_a), 32'd0);
      q = '{8'h96};
      push_a(8'h96, t0);
      wait_idle_a(30);
      check_wave(q, t0);
      drain_check_a(q);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
